sender80211_fcs_serializer: RTL and testbench
=============================================

# sender80211_fcs_serializer

Datapath stage downstream of the sender80211 AXI4-Lite register block. It consumes 32-bit payload words written through the register interface and serializes them into an 8-bit byte stream. It computes the 802.11 FCS (IEEE CRC-32) over the payload and appends it as four trailing bytes. The output stream feeds the PHY-side byte interface of the sender.

## Interface
Parameters:
- MAX_PAYLOAD_BYTES, 2312, payload length above which `oversize` is set.
- COUNT_WIDTH, 16, width of `frame_count`.

Ports:
- ACLK  in  1  single clock; all logic on its rising edge.
- ARESET  in  1  reset, synchronous and active-high.
- s_tdata  in  32  payload word, little-endian: byte0 = [7:0], sent first.
- s_tvalid  in  1  input beat valid.
- s_tready  out  1  input beat accepted when `s_tvalid & s_tready`.
- s_tlast  in  1  last beat of frame.
- s_tbytes  in  2  valid bytes minus one on the last beat (0→1 byte … 3→4 bytes). Ignored when `s_tlast=0`, where 4 bytes are implied.
- m_tdata  out  8  output byte.
- m_tvalid  out  1  output byte valid.
- m_tready  in  1  downstream accepts when `m_tvalid & m_tready`.
- m_tlast  out  1  high on the final FCS byte only.
- frame_count  out  COUNT_WIDTH  completed frames. Wraps modulo 2^COUNT_WIDTH.
- oversize  out  1  sticky. Set when any frame's payload exceeded MAX_PAYLOAD_BYTES.

## Operation
- FSM states:
  - LOAD: s_tready=1, m_tvalid=0.
  - SHIFT: emit payload bytes.
  - FCS: emit 4 FCS bytes.
- LOAD transitions:
  - On a `s_tvalid & s_tready` handshake, capture s_tdata, s_tlast and the byte count (4, or s_tbytes+1 when last) into the word register.
  - Set byte index to 0 and go to SHIFT.
- SHIFT behaviour:
  - m_tdata = word_reg[8*idx +: 8], m_tvalid=1, m_tlast=0.
  - Each output handshake folds the byte into the CRC, increments idx and increments the 12-bit payload byte counter.
- SHIFT exit, on the handshake of the last valid byte of the word:
  - Word not last: go to LOAD.
  - Word last: go to FCS with fcs_idx=0.
- CRC-32 rules:
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, updated one byte per cycle, LSB-first.
  - FCS byte k = ~crc[8k+7:8k], for k = 0..3.
  - The CRC register does not change in FCS.
- FCS behaviour:
  - m_tvalid=1. m_tlast=1 when fcs_idx=3.
  - On the handshake with fcs_idx=3: go to LOAD, reinit the CRC to 0xFFFFFFFF, clear the byte counter, increment frame_count.
- Oversize:
  - If the byte counter exceeds MAX_PAYLOAD_BYTES, set `oversize`. It clears only on ARESET.
  - The frame is still passed through unmodified, with its FCS.
  - The byte counter saturates at 4095.
- A zero-length frame cannot occur: a last beat always carries at least 1 byte.

## Timing
- Reset values: s_tready=0 during reset and 1 the cycle after (LOAD); m_tvalid=0; m_tlast=0; m_tdata=0; frame_count=0; oversize=0; CRC=0xFFFFFFFF.
- Latency: a beat accepted at edge N gives byte0 on m_tdata/m_tvalid after edge N.
- Throughput: one byte per cycle while m_tready=1, plus one LOAD bubble per input word. A full word therefore takes 5 cycles.
- s_tready depends only on state (registered). There is no combinational path from m_tready.
- While `m_tvalid & !m_tready`, m_tdata and m_tlast hold stable. m_tvalid never drops without a handshake except on ARESET.
- Reset mid-frame: all state returns to reset values at the next edge. The partial frame is abandoned with no m_tlast emitted, and frame_count is not incremented.
- If s_tvalid is asserted while in LOAD in the same cycle that FCS completes, the beat is not taken. It is taken in the following LOAD cycle.

## Structure
- Package `sender80211_pkg` holds:
  - CRC32_POLY = 32'hEDB88320, CRC32_INIT = 32'hFFFFFFFF, CRC32_RESIDUE = 32'hDEBB20E3.
  - State enum {LOAD, SHIFT, FCS}.
  - Function crc32_update_byte(crc, byte).
- One sub-module, `sender80211_crc32`: the CRC register with ports init, en, byte in and crc out, synchronous to ACLK/ARESET.

## Test plan
- Payload "123456789" (words 0x34333231, 0x38373635, then 0x00000039 with last, s_tbytes=0), m_tready=1 → bytes 31…39, 26, 39, F4, CB. m_tlast on CB, frame_count=1.
- Single byte 0x00 (s_tlast=1, s_tbytes=0) → 00, 8D, EF, 02, D2, with tlast on D2.
- Payload "123456789" with m_tready random at 50% → identical byte sequence, no drops or duplicates, m_tdata stable while stalled.
- Assert ARESET after 3 output bytes → m_tvalid=0 and frame_count=0 next cycle. A following "123456789" frame produces the correct FCS CB F4 39 26 (wire order 26 39 F4 CB).
- 2313-byte payload → oversize=1 after the byte-2313 handshake, FCS still appended, frame_count increments, oversize stays 1 across the next normal frame.
- Two back-to-back "123456789" frames with s_tvalid held high → both end in 26 39 F4 CB (CRC reinitialised), frame_count=2.

Source files
------------

// File: rtl/sender80211_pkg.sv
// Shared constants, state encoding and the byte-wise CRC-32 step for the
// sender80211 FCS serializer.
package sender80211_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        FCS   = 2'd2
    } state_t;

    // Reflected CRC-32, one byte folded in LSB-first.
    function automatic logic [31:0] crc32_update_byte(input logic [31:0] crc,
                                                      input logic [7:0]  data_byte);
        logic [31:0] c;
        c = crc ^ {24'h000000, data_byte};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/sender80211_fcs_serializer_crc32.sv
// CRC-32 accumulator register for the FCS serializer; one byte per enabled cycle.
module sender80211_crc32
    import sender80211_pkg::*;
(
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data_byte,
    output logic [31:0] crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC32_INIT;
        end else if (en) begin
            crc_d = crc32_update_byte(crc_q, data_byte);
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            crc_q <= CRC32_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sender80211_fcs_serializer.sv
// Serializes 32-bit payload words into a byte stream and appends the 802.11 FCS.
//   state | meaning
//   LOAD  | waiting for the next payload word (s_tready=1)
//   SHIFT | emitting payload bytes of the held word
//   FCS   | emitting the four FCS bytes, m_tlast on the final one
module sender80211_fcs_serializer
    import sender80211_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD_BYTES = 2312,
    parameter int unsigned COUNT_WIDTH       = 16
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [31:0]            s_tdata,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic                   s_tlast,
    input  logic [1:0]             s_tbytes,
    output logic [7:0]             m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic [COUNT_WIDTH-1:0] frame_count,
    output logic                   oversize
);

    state_t                 state_q, state_d;
    logic [31:0]            word_q, word_d;
    logic                   last_q, last_d;
    logic [1:0]             lastidx_q, lastidx_d;
    logic [1:0]             idx_q, idx_d;
    logic [1:0]             fcs_idx_q, fcs_idx_d;
    logic [11:0]            bcnt_q, bcnt_d;
    logic [COUNT_WIDTH-1:0] fcnt_q, fcnt_d;
    logic                   ovs_q, ovs_d;

    logic                   crc_init;
    logic                   crc_en;
    logic [31:0]            crc_val;

    sender80211_crc32 u_crc (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .init      (crc_init),
        .en        (crc_en),
        .data_byte (m_tdata),
        .crc       (crc_val)
    );

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        last_d    = last_q;
        lastidx_d = lastidx_q;
        idx_d     = idx_q;
        fcs_idx_d = fcs_idx_q;
        bcnt_d    = bcnt_q;
        fcnt_d    = fcnt_q;
        ovs_d     = ovs_q;
        crc_init  = 1'b0;
        crc_en    = 1'b0;
        // Gated by ARESET so the source sees no ready while reset is held.
        s_tready  = (state_q == LOAD) && !ARESET;
        m_tvalid  = 1'b0;
        m_tlast   = 1'b0;
        m_tdata   = 8'h00;

        case (state_q)
            LOAD: begin
                if (s_tvalid && s_tready) begin
                    word_d    = s_tdata;
                    last_d    = s_tlast;
                    lastidx_d = s_tlast ? s_tbytes : 2'd3;
                    idx_d     = 2'd0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                m_tvalid = 1'b1;
                m_tdata  = word_q[{idx_q, 3'b000} +: 8];
                if (m_tready) begin
                    crc_en = 1'b1;
                    idx_d  = idx_q + 2'd1;
                    if (bcnt_q != 12'hFFF) begin
                        bcnt_d = bcnt_q + 12'd1;
                    end
                    if (idx_q == lastidx_q) begin
                        if (last_q) begin
                            state_d   = FCS;
                            fcs_idx_d = 2'd0;
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
            end
            FCS: begin
                m_tvalid = 1'b1;
                m_tdata  = ~crc_val[{fcs_idx_q, 3'b000} +: 8];
                m_tlast  = (fcs_idx_q == 2'd3);
                if (m_tready) begin
                    fcs_idx_d = fcs_idx_q + 2'd1;
                    if (fcs_idx_q == 2'd3) begin
                        state_d  = LOAD;
                        crc_init = 1'b1;
                        bcnt_d   = 12'd0;
                        fcnt_d   = fcnt_q + COUNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        if ({20'd0, bcnt_d} > MAX_PAYLOAD_BYTES) begin
            ovs_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= LOAD;
            word_q    <= 32'h0;
            last_q    <= 1'b0;
            lastidx_q <= 2'd0;
            idx_q     <= 2'd0;
            fcs_idx_q <= 2'd0;
            bcnt_q    <= 12'd0;
            fcnt_q    <= '0;
            ovs_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            last_q    <= last_d;
            lastidx_q <= lastidx_d;
            idx_q     <= idx_d;
            fcs_idx_q <= fcs_idx_d;
            bcnt_q    <= bcnt_d;
            fcnt_q    <= fcnt_d;
            ovs_q     <= ovs_d;
        end
    end

    assign frame_count = fcnt_q;
    assign oversize    = ovs_q;

endmodule

// File: tb/tb_sender80211_fcs_serializer.sv
// Directed bench for the FCS serializer: known CRC-32 vectors, stalls, reset, oversize.
module tb_sender80211_fcs_serializer;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [31:0] s_tdata = 32'h0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [1:0]  s_tbytes = 2'd0;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic [15:0] frame_count;
    logic        oversize;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0] pay[$];
    logic [8:0] exp_q[$];
    logic [8:0] rx_q[$];
    int stall_err;
    int stall_seen;
    int timeouts;
    int first_ovs;

    // "123456789" followed by its FCS in wire order
    logic [7:0] EXP9[13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                             8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
    logic [7:0] EXP1[5]  = '{8'h00, 8'h8D, 8'hEF, 8'h02, 8'hD2};

    always #5 ACLK = ~ACLK;

    sender80211_fcs_serializer dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tlast     (s_tlast),
        .s_tbytes    (s_tbytes),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tlast     (m_tlast),
        .frame_count (frame_count),
        .oversize    (oversize)
    );

    function automatic logic [31:0] ref_fcs();
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (pay[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ pay[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic load_123();
        pay.delete();
        for (int i = 0; i < 9; i++) pay.push_back(8'(8'h31 + i));
    endtask

    task automatic push_exp9();
        for (int i = 0; i < 13; i++) exp_q.push_back({(i == 12), EXP9[i]});
    endtask

    task automatic send_payload(input bit hold);
        int n;
        int t;
        n = pay.size();
        for (int i = 0; i < n; i += 4) begin
            logic [31:0] w;
            int          cnt;
            cnt = (n - i >= 4) ? 4 : n - i;
            w = 32'h0;
            for (int j = 0; j < cnt; j++) w[8*j +: 8] = pay[i+j];
            s_tdata  = w;
            s_tvalid = 1'b1;
            s_tlast  = (i + cnt >= n);
            s_tbytes = 2'(cnt - 1);
            t = 0;
            do begin
                @(negedge ACLK);
                t++;
            end while (!s_tready && t < 200);
            if (!s_tready) timeouts++;
            @(posedge ACLK);
            #1;
        end
        if (!hold) begin
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
        end
    endtask

    task automatic collect(input int ready_pct, input int budget);
        bit         prev_stall;
        bit         done;
        logic [7:0] hd;
        logic       hl;
        prev_stall = 1'b0;
        done = 1'b0;
        hd = 8'h0;
        hl = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge ACLK);
            #1;
            m_tready = (int'($urandom_range(99)) < ready_pct);
            @(negedge ACLK);
            if (prev_stall) begin
                stall_seen++;
                if (!m_tvalid || m_tdata !== hd || m_tlast !== hl) stall_err++;
            end
            if (oversize === 1'b1 && first_ovs < 0) first_ovs = rx_q.size();
            prev_stall = m_tvalid && !m_tready;
            hd = m_tdata;
            hl = m_tlast;
            if (m_tvalid && m_tready) begin
                rx_q.push_back({m_tlast, m_tdata});
                if (m_tlast) begin
                    done = 1'b1;
                    break;
                end
            end
        end
        if (!done) timeouts++;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        vec_cnt++; if (s_tready !== 1'b0) begin err_cnt++; $display("FAIL rst_s_tready got %b want 0", s_tready); end
        vec_cnt++; if (m_tvalid !== 1'b0) begin err_cnt++; $display("FAIL rst_m_tvalid got %b want 0", m_tvalid); end
        vec_cnt++; if (m_tlast !== 1'b0) begin err_cnt++; $display("FAIL rst_m_tlast got %b want 0", m_tlast); end
        vec_cnt++; if (m_tdata !== 8'h00) begin err_cnt++; $display("FAIL rst_m_tdata got %h want 00", m_tdata); end
        vec_cnt++; if (frame_count !== 16'd0) begin err_cnt++; $display("FAIL rst_frame_count got %0d want 0", frame_count); end
        vec_cnt++; if (oversize !== 1'b0) begin err_cnt++; $display("FAIL rst_oversize got %b want 0", oversize); end
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        vec_cnt++; if (s_tready !== 1'b1) begin err_cnt++; $display("FAIL post_rst_s_tready got %b want 1", s_tready); end
    endtask

    task automatic test_check_vector();
        int bad;
        @(posedge ACLK);
        #1;
        load_123();
        exp_q.delete(); rx_q.delete(); push_exp9();
        m_tready = 1'b1;
        fork
            send_payload(1'b0);
            collect(100, 200);
        join
        @(negedge ACLK);
        bad = 0;
        foreach (exp_q[i]) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
        vec_cnt++; if (rx_q.size() != 13) begin err_cnt++; $display("FAIL chk9_len got %0d want 13", rx_q.size()); end
        vec_cnt++; if (bad != 0) begin err_cnt++; $display("FAIL chk9_bytes got %0d bad bytes want 0", bad); end
        vec_cnt++; if (frame_count !== 16'd1) begin err_cnt++; $display("FAIL chk9_frame_count got %0d want 1", frame_count); end
    endtask

    task automatic test_single_byte();
        @(posedge ACLK);
        #1;
        m_tready = 1'b1;
        s_tdata  = 32'hA5A5A500;
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        s_tbytes = 2'd0;
        @(negedge ACLK);
        vec_cnt++; if (s_tready !== 1'b1) begin err_cnt++; $display("FAIL one_load_ready got %b want 1", s_tready); end
        @(posedge ACLK);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            vec_cnt++;
            if (m_tvalid !== 1'b1 || m_tdata !== EXP1[k] || m_tlast !== (k == 4)) begin
                err_cnt++;
                $display("FAIL one_byte%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         k, m_tvalid, m_tdata, m_tlast, EXP1[k], (k == 4));
            end
            if (k == 0) begin
                vec_cnt++; if (s_tready !== 1'b0) begin err_cnt++; $display("FAIL one_shift_ready got %b want 0", s_tready); end
            end
        end
        @(negedge ACLK);
        vec_cnt++; if (m_tvalid !== 1'b0) begin err_cnt++; $display("FAIL one_idle_valid got %b want 0", m_tvalid); end
        vec_cnt++; if (frame_count !== 16'd2) begin err_cnt++; $display("FAIL one_frame_count got %0d want 2", frame_count); end
    endtask

    task automatic test_random_stall();
        int bad;
        @(posedge ACLK);
        #1;
        load_123();
        exp_q.delete(); rx_q.delete(); push_exp9();
        stall_err = 0;
        stall_seen = 0;
        fork
            send_payload(1'b0);
            collect(50, 500);
        join
        @(negedge ACLK);
        bad = 0;
        foreach (exp_q[i]) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
        vec_cnt++; if (rx_q.size() != 13) begin err_cnt++; $display("FAIL stall_len got %0d want 13", rx_q.size()); end
        vec_cnt++; if (bad != 0) begin err_cnt++; $display("FAIL stall_bytes got %0d bad bytes want 0", bad); end
        vec_cnt++; if (stall_err != 0) begin err_cnt++; $display("FAIL stall_hold got %0d unstable cycles want 0 (of %0d)", stall_err, stall_seen); end
        vec_cnt++; if (frame_count !== 16'd3) begin err_cnt++; $display("FAIL stall_frame_count got %0d want 3", frame_count); end
    endtask

    task automatic test_reset_midframe();
        int bad;
        @(posedge ACLK);
        #1;
        m_tready = 1'b1;
        s_tdata  = 32'h34333231;
        s_tvalid = 1'b1;
        s_tlast  = 1'b0;
        s_tbytes = 2'd0;
        @(posedge ACLK);
        #1;
        s_tvalid = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        @(negedge ACLK);
        vec_cnt++; if (m_tdata !== 8'h34) begin err_cnt++; $display("FAIL mid_byte3 got %h want 34", m_tdata); end
        ARESET = 1'b1;
        @(posedge ACLK);
        #1;
        @(negedge ACLK);
        vec_cnt++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_out got v=%b l=%b want 0 0", m_tvalid, m_tlast); end
        vec_cnt++; if (frame_count !== 16'd0) begin err_cnt++; $display("FAIL mid_rst_count got %0d want 0", frame_count); end
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        load_123();
        exp_q.delete(); rx_q.delete(); push_exp9();
        fork
            send_payload(1'b0);
            collect(100, 200);
        join
        @(negedge ACLK);
        bad = 0;
        foreach (exp_q[i]) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
        vec_cnt++; if (rx_q.size() != 13 || bad != 0) begin err_cnt++; $display("FAIL mid_refrm got len=%0d bad=%0d want 13 0", rx_q.size(), bad); end
        vec_cnt++; if (frame_count !== 16'd1) begin err_cnt++; $display("FAIL mid_refrm_count got %0d want 1", frame_count); end
    endtask

    task automatic test_oversize();
        int          bad;
        logic [31:0] f;
        @(posedge ACLK);
        #1;
        pay.delete();
        for (int i = 0; i < 2313; i++) pay.push_back(8'(i * 7 + 3));
        f = ref_fcs();
        exp_q.delete(); rx_q.delete();
        foreach (pay[i]) exp_q.push_back({1'b0, pay[i]});
        for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), f[8*k +: 8]});
        first_ovs = -1;
        vec_cnt++; if (oversize !== 1'b0) begin err_cnt++; $display("FAIL ovs_pre got %b want 0", oversize); end
        fork
            send_payload(1'b0);
            collect(100, 4000);
        join
        @(negedge ACLK);
        bad = 0;
        foreach (exp_q[i]) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
        vec_cnt++; if (rx_q.size() != 2317 || bad != 0) begin err_cnt++; $display("FAIL ovs_stream got len=%0d bad=%0d want 2317 0", rx_q.size(), bad); end
        vec_cnt++; if (first_ovs != 2313) begin err_cnt++; $display("FAIL ovs_onset got %0d bytes want 2313", first_ovs); end
        vec_cnt++; if (frame_count !== 16'd2) begin err_cnt++; $display("FAIL ovs_frame_count got %0d want 2", frame_count); end
    endtask

    task automatic test_back_to_back();
        int bad;
        @(posedge ACLK);
        #1;
        load_123();
        exp_q.delete(); rx_q.delete(); push_exp9(); push_exp9();
        fork
            begin
                send_payload(1'b1);
                send_payload(1'b0);
            end
            begin
                collect(100, 200);
                collect(100, 200);
            end
        join
        @(negedge ACLK);
        bad = 0;
        foreach (exp_q[i]) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
        vec_cnt++; if (rx_q.size() != 26 || bad != 0) begin err_cnt++; $display("FAIL b2b_stream got len=%0d bad=%0d want 26 0", rx_q.size(), bad); end
        vec_cnt++; if (frame_count !== 16'd4) begin err_cnt++; $display("FAIL b2b_frame_count got %0d want 4", frame_count); end
        vec_cnt++; if (oversize !== 1'b1) begin err_cnt++; $display("FAIL b2b_oversize_sticky got %b want 1", oversize); end
    endtask

    initial begin
        timeouts = 0;
        stall_err = 0;
        stall_seen = 0;
        first_ovs = -1;
        test_reset();
        test_check_vector();
        test_single_byte();
        test_random_stall();
        test_reset_midframe();
        test_oversize();
        test_back_to_back();
        vec_cnt++; if (timeouts != 0) begin err_cnt++; $display("FAIL handshake_timeouts got %0d want 0", timeouts); end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
